mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum WAIT-state cycles allowed before a load is aborted.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 arstn  in  1  asynchronous active-low reset.
REQ-004 in_valid_i  in  1  ALU-stage result valid.
REQ-005 in_ready_o  out  1  stage accepts input; high only in IDLE.
REQ-006 mem_op_i  in  2  operation: 0 none, 1 load, 2 store, 3 reserved (treated as none).
REQ-007 alu_res_i  in  32  ALU result; used as address for load/store, as writeback data for none.
REQ-008 st_data_i  in  32  store data.
REQ-009 wb_wr_i  in  1  writeback enable from ALU stage.
REQ-010 reg_dst_i  in  5  destination register.
REQ-011 dmem_req_o  out  1  data-memory request.
REQ-012 dmem_we_o  out  1  1 store, 0 load.
REQ-013 dmem_addr_o  out  32  request address.
REQ-014 dmem_wdata_o  out  32  store data.
REQ-015 dmem_gnt_i  in  1  request accepted.
REQ-016 dmem_rvalid_i  in  1  load data valid.
REQ-017 dmem_rdata_i  in  32  load data.
REQ-018 wb_valid_o  out  1  one-cycle pulse; writeback result valid.
REQ-019 wb_wr_o  out  1  register write enable to writeback.
REQ-020 wb_reg_dst_o  out  5  destination register to writeback.
REQ-021 wb_data_o  out  32  writeback data.
REQ-022 mem_busy_o  out  1  stall request to control; equals state != IDLE.
REQ-023 mem_err_o  out  1  one-cycle pulse on load timeout or misaligned access.

Function
REQ-024 FSM states: IDLE, REQ, WAIT; IDLE is the reset state.
REQ-025 IDLE with in_valid_i and op none/reserved: register alu_res_i, wb_wr_i and reg_dst_i to the wb outputs and pulse wb_valid_o the next cycle (latency 1); remain in IDLE.
REQ-026 IDLE with in_valid_i and op load/store: latch op, address, store data, wb_wr and reg_dst; go to REQ; no wb pulse.
REQ-027 REQ: dmem_req_o=1, with dmem_we_o, dmem_addr_o and dmem_wdata_o driven from latched values and held stable until dmem_gnt_i.
REQ-028 REQ with gnt on a store: go to IDLE; pulse wb_valid_o the next cycle with wb_wr_o=0.
REQ-029 REQ with gnt on a load: go to WAIT; clear the timeout counter.
REQ-030 WAIT with dmem_rvalid_i: wb_data_o=dmem_rdata_i, wb_wr_o=latched wb_wr, wb_valid_o pulses the next cycle; go to IDLE.
REQ-031 WAIT without rvalid: counter increments each cycle; when the counter equals TIMEOUT, pulse mem_err_o, pulse wb_valid_o with wb_wr_o=0, and go to IDLE.
REQ-032 rvalid_i arriving on the cycle the counter reaches TIMEOUT takes priority: data is accepted and no error is raised.
REQ-033 dmem_rvalid_i outside WAIT is ignored.
REQ-034 dmem_req_o is 0 in IDLE and WAIT; exactly one request per memory op.
REQ-035 Outputs are registered; wb_data_o, wb_wr_o and wb_reg_dst_o hold their last values when wb_valid_o=0.

Reset
REQ-036 arstn low forces IDLE, counter 0, all outputs 0 except in_ready_o=1, effective immediately and independent of clk.
REQ-037 Reset during REQ or WAIT abandons the transaction; no wb pulse or error follows deassertion.

Configuration
REQ-038 Macro MEM_MISALIGN_CHECK_EN defined: a load/store in IDLE with alu_res_i[1:0]!=0 issues no request, pulses mem_err_o and pulses wb_valid_o with wb_wr_o=0 the next cycle, and stays in IDLE.
REQ-039 MEM_MISALIGN_CHECK_EN undefined: address bits [1:0] are ignored and misaligned accesses proceed normally; mem_err_o is driven only by timeout.

Verification
REQ-040 Op none, alu_res=0x0000_00AA, reg_dst=5, wb_wr=1 -> next cycle wb_valid=1, wb_data=0xAA, wb_reg_dst=5.
REQ-041 Load addr 0x100, gnt after 2 cycles, rvalid with 0xDEADBEEF 3 cycles later -> dmem_req held 3 cycles, then wb_data=0xDEADBEEF with wb_wr=1 and mem_busy low afterwards.
REQ-042 Store addr 0x200, data 0x1234, immediate gnt -> one req cycle with we=1, then wb_valid=1 with wb_wr=0.
REQ-043 Load with no rvalid -> mem_err_o pulses TIMEOUT cycles after gnt, with wb_wr=0; rvalid on that same cycle -> no error.
REQ-044 Load addr 0x102 -> error pulse and no request when MEM_MISALIGN_CHECK_EN is defined; normal load when it is undefined.
REQ-045 arstn low during WAIT -> IDLE and outputs 0 at once; a late rvalid after release -> no wb_valid.

Source files
------------

// File: rtl/mem_stage_if.sv
// Bus bundle for mem_stage: ALU-stage input, data-memory port and writeback output.
interface mem_stage_if;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [1:0]  mem_op_i;
    logic [31:0] alu_res_i;
    logic [31:0] st_data_i;
    logic        wb_wr_i;
    logic [4:0]  reg_dst_i;

    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;

    logic        wb_valid_o;
    logic        wb_wr_o;
    logic [4:0]  wb_reg_dst_o;
    logic [31:0] wb_data_o;
    logic        mem_busy_o;
    logic        mem_err_o;

    modport slave (
        input  in_valid_i, mem_op_i, alu_res_i, st_data_i, wb_wr_i, reg_dst_i,
        input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
        output in_ready_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
        output wb_valid_o, wb_wr_o, wb_reg_dst_o, wb_data_o, mem_busy_o, mem_err_o
    );

    modport master (
        output in_valid_i, mem_op_i, alu_res_i, st_data_i, wb_wr_i, reg_dst_i,
        output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
        input  in_ready_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
        input  wb_valid_o, wb_wr_o, wb_reg_dst_o, wb_data_o, mem_busy_o, mem_err_o
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: passes ALU results through or runs one load/store on the data port.
// Optional macro MEM_MISALIGN_CHECK_EN rejects load/store addresses with bits [1:0] != 0.
module mem_stage #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       arstn,
    mem_stage_if.slave bus
);
    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]    state;
    logic          lat_we;
    logic          lat_wr;
    logic [31:0]   lat_addr;
    logic [31:0]   lat_wdata;
    logic [4:0]    lat_dst;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    logic          wb_valid;
    logic          wb_wr;
    logic [4:0]    wb_dst;
    logic [31:0]   wb_data;
    logic          mem_err;

    logic          is_mem;
    logic          misalign;

    assign is_mem  = (bus.mem_op_i == 2'd1) || (bus.mem_op_i == 2'd2);
    assign cnt_nxt = cnt + 1'b1;

`ifdef MEM_MISALIGN_CHECK_EN
    assign misalign = (bus.alu_res_i[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // wb_data only changes for pass-through and load data; store/abort/error pulses keep it.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state     <= S_IDLE;
            lat_we    <= 1'b0;
            lat_wr    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_dst   <= '0;
            cnt       <= '0;
            wb_valid  <= 1'b0;
            wb_wr     <= 1'b0;
            wb_dst    <= '0;
            wb_data   <= '0;
            mem_err   <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            mem_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.in_valid_i) begin
                        if (!is_mem) begin
                            wb_valid <= 1'b1;
                            wb_wr    <= bus.wb_wr_i;
                            wb_dst   <= bus.reg_dst_i;
                            wb_data  <= bus.alu_res_i;
                        end else if (misalign) begin
                            wb_valid <= 1'b1;
                            wb_wr    <= 1'b0;
                            wb_dst   <= bus.reg_dst_i;
                            mem_err  <= 1'b1;
                        end else begin
                            lat_we    <= (bus.mem_op_i == 2'd2);
                            lat_addr  <= bus.alu_res_i;
                            lat_wdata <= bus.st_data_i;
                            lat_wr    <= bus.wb_wr_i;
                            lat_dst   <= bus.reg_dst_i;
                            state     <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (bus.dmem_gnt_i) begin
                        if (lat_we) begin
                            state    <= S_IDLE;
                            wb_valid <= 1'b1;
                            wb_wr    <= 1'b0;
                            wb_dst   <= lat_dst;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= '0;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.dmem_rvalid_i) begin
                        state    <= S_IDLE;
                        wb_valid <= 1'b1;
                        wb_wr    <= lat_wr;
                        wb_dst   <= lat_dst;
                        wb_data  <= bus.dmem_rdata_i;
                    end else if (cnt_nxt == TO_LIM) begin
                        state    <= S_IDLE;
                        wb_valid <= 1'b1;
                        wb_wr    <= 1'b0;
                        wb_dst   <= lat_dst;
                        mem_err  <= 1'b1;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready_o   = (state == S_IDLE);
    assign bus.mem_busy_o   = (state != S_IDLE);
    assign bus.dmem_req_o   = (state == S_REQ);
    assign bus.dmem_we_o    = lat_we;
    assign bus.dmem_addr_o  = lat_addr;
    assign bus.dmem_wdata_o = lat_wdata;
    assign bus.wb_valid_o   = wb_valid;
    assign bus.wb_wr_o      = wb_wr;
    assign bus.wb_reg_dst_o = wb_dst;
    assign bus.wb_data_o    = wb_data;
    assign bus.mem_err_o    = mem_err;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: transaction-level expectation queue plus per-cycle output monitor.
module tb_mem_stage;
    localparam int unsigned TO = 15;

    logic clk   = 1'b0;
    logic arstn = 1'b0;
    always #5 clk = ~clk;

    mem_stage_if bus ();

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk  (clk),
        .arstn(arstn),
        .bus  (bus)
    );

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // One expected writeback pulse; keep=1 means wb_data must stay at its previous value.
    typedef struct {
        logic        wr;
        logic [4:0]  dst;
        logic [31:0] data;
        logic        keep;
        logic        err;
    } wb_exp_t;

    wb_exp_t     expq[$];
    logic [31:0] m_data = '0;
    logic [4:0]  m_dst  = '0;
    logic        m_wr   = 1'b0;
    bit          mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en && arstn) begin
            chk1("busy_vs_ready", bus.mem_busy_o, ~bus.in_ready_o);
            chk1("req_implies_busy", bus.dmem_req_o & ~bus.mem_busy_o, 1'b0);
            if (bus.wb_valid_o) begin
                if (expq.size() == 0) begin
                    chk1("unexpected_wb_valid", bus.wb_valid_o, 1'b0);
                end else begin
                    wb_exp_t e;
                    e = expq.pop_front();
                    if (!e.keep) m_data = e.data;
                    m_wr  = e.wr;
                    m_dst = e.dst;
                    chk1 ("wb_wr", bus.wb_wr_o, m_wr);
                    check("wb_reg_dst", {27'b0, bus.wb_reg_dst_o}, {27'b0, m_dst});
                    check("wb_data", bus.wb_data_o, m_data);
                    chk1 ("mem_err", bus.mem_err_o, e.err);
                end
            end else begin
                chk1 ("hold_wb_wr", bus.wb_wr_o, m_wr);
                check("hold_wb_reg_dst", {27'b0, bus.wb_reg_dst_o}, {27'b0, m_dst});
                check("hold_wb_data", bus.wb_data_o, m_data);
                chk1 ("err_without_wb", bus.mem_err_o, 1'b0);
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] alu, input logic [31:0] sd,
                         input logic wr, input logic [4:0] dst);
        chk1("in_ready_at_issue", bus.in_ready_o, 1'b1);
        bus.in_valid_i = 1'b1;
        bus.mem_op_i   = op;
        bus.alu_res_i  = alu;
        bus.st_data_i  = sd;
        bus.wb_wr_i    = wr;
        bus.reg_dst_i  = dst;
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
        bus.mem_op_i   = 2'd0;
        bus.alu_res_i  = 32'hFFFF_FFFF;
    endtask

    task automatic run_none(input logic [1:0] op, input logic [31:0] alu, input logic wr,
                            input logic [4:0] dst);
        wb_exp_t e;
        e.wr = wr; e.dst = dst; e.data = alu; e.keep = 1'b0; e.err = 1'b0;
        expq.push_back(e);
        issue(op, alu, 32'h0, wr, dst);
        @(negedge clk);
        chk1("none_wb_valid_lat1", bus.wb_valid_o, 1'b1);
        chk1("none_stays_idle", bus.in_ready_o, 1'b1);
        @(posedge clk);
        #1;
    endtask

    // rv_dly < 0: no read data ever; otherwise rvalid on WAIT cycle rv_dly (0-based).
    task automatic run_mem(input bit store, input logic [31:0] addr, input logic [31:0] sd,
                           input logic wr, input logic [4:0] dst, input int gnt_dly,
                           input int rv_dly, input logic [31:0] rdata);
        wb_exp_t e;
        logic    misal;
        logic    exp_err;
        int      waits;
        misal = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
        misal = (addr[1:0] != 2'b00);
`endif
        e.dst = dst; e.data = rdata; e.keep = 1'b1; e.wr = 1'b0;
        if (misal)              e.err = 1'b1;
        else if (store)         e.err = 1'b0;
        else if (rv_dly >= 0) begin
            e.err = 1'b0; e.wr = wr; e.keep = 1'b0;
        end else                e.err = 1'b1;
        exp_err = e.err;
        expq.push_back(e);
        issue(store ? 2'd2 : 2'd1, addr, sd, wr, dst);
        if (misal) begin
            @(negedge clk);
            chk1("misalign_no_req", bus.dmem_req_o, 1'b0);
            chk1("misalign_err", bus.mem_err_o, 1'b1);
            chk1("misalign_wb_valid", bus.wb_valid_o, 1'b1);
            @(posedge clk);
            #1;
            return;
        end
        for (int i = 0; i <= gnt_dly; i++) begin
            @(negedge clk);
            chk1 ("req_held", bus.dmem_req_o, 1'b1);
            chk1 ("req_we", bus.dmem_we_o, store);
            check("req_addr", bus.dmem_addr_o, addr);
            if (store) check("req_wdata", bus.dmem_wdata_o, sd);
            bus.dmem_gnt_i    = (i == gnt_dly);
            bus.dmem_rvalid_i = 1'b1;
            bus.dmem_rdata_i  = 32'hBADB_AD00;
            @(posedge clk);
            #1;
        end
        bus.dmem_gnt_i    = 1'b0;
        bus.dmem_rvalid_i = 1'b0;
        if (!store) begin
            waits = (rv_dly >= 0) ? rv_dly + 1 : int'(TO);
            for (int j = 0; j < waits; j++) begin
                @(negedge clk);
                chk1("wait_no_req", bus.dmem_req_o, 1'b0);
                chk1("wait_busy", bus.mem_busy_o, 1'b1);
                chk1("wait_no_wb", bus.wb_valid_o, 1'b0);
                bus.dmem_rvalid_i = (j == rv_dly);
                bus.dmem_rdata_i  = rdata;
                @(posedge clk);
                #1;
            end
            bus.dmem_rvalid_i = 1'b0;
        end
        @(negedge clk);
        chk1("done_wb_valid", bus.wb_valid_o, 1'b1);
        chk1("done_not_busy", bus.mem_busy_o, 1'b0);
        chk1("done_no_req", bus.dmem_req_o, 1'b0);
        chk1("done_err", bus.mem_err_o, exp_err);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid_i    = 1'b0;
        bus.mem_op_i      = 2'd0;
        bus.alu_res_i     = '0;
        bus.st_data_i     = '0;
        bus.wb_wr_i       = 1'b0;
        bus.reg_dst_i     = '0;
        bus.dmem_gnt_i    = 1'b0;
        bus.dmem_rvalid_i = 1'b0;
        bus.dmem_rdata_i  = '0;

        #3;
        chk1 ("rst_in_ready", bus.in_ready_o, 1'b1);
        chk1 ("rst_busy", bus.mem_busy_o, 1'b0);
        chk1 ("rst_req", bus.dmem_req_o, 1'b0);
        chk1 ("rst_wb_valid", bus.wb_valid_o, 1'b0);
        check("rst_wb_data", bus.wb_data_o, 32'h0);
        chk1 ("rst_err", bus.mem_err_o, 1'b0);
        @(negedge clk);
        arstn = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        run_none(2'd0, 32'h0000_00AA, 1'b1, 5'd5);
        check("lit_none_data", bus.wb_data_o, 32'h0000_00AA);
        check("lit_none_dst", {27'b0, bus.wb_reg_dst_o}, 32'd5);
        run_none(2'd3, 32'h1234_5678, 1'b0, 5'd31);

        run_mem(1'b0, 32'h0000_0100, 32'h0, 1'b1, 5'd7, 2, 2, 32'hDEAD_BEEF);
        check("lit_load_data", bus.wb_data_o, 32'hDEAD_BEEF);
        chk1 ("lit_load_wr", bus.wb_wr_o, 1'b1);
        chk1 ("lit_load_not_busy", bus.mem_busy_o, 1'b0);

        run_mem(1'b1, 32'h0000_0200, 32'h0000_1234, 1'b1, 5'd9, 0, -1, 32'h0);
        chk1 ("lit_store_wr", bus.wb_wr_o, 1'b0);
        check("lit_store_keeps_data", bus.wb_data_o, 32'hDEAD_BEEF);

        run_mem(1'b0, 32'h0000_0104, 32'h0, 1'b1, 5'd3, 1, -1, 32'h0);
        chk1("lit_timeout_wr", bus.wb_wr_o, 1'b0);

        run_mem(1'b0, 32'h0000_0108, 32'h0, 1'b1, 5'd4, 0, int'(TO) - 1, 32'hCAFE_F00D);
        check("lit_edge_data", bus.wb_data_o, 32'hCAFE_F00D);

        run_mem(1'b0, 32'h0000_0102, 32'h0, 1'b1, 5'd6, 1, 0, 32'h0BAD_F00D);
        run_mem(1'b1, 32'h0000_0203, 32'hA5A5_5A5A, 1'b0, 5'd2, 3, -1, 32'h0);

        run_none(2'd0, 32'h0000_0077, 1'b1, 5'd12);
        run_mem(1'b0, 32'h0000_0400, 32'h0, 1'b0, 5'd13, 0, 0, 32'h1111_2222);

        bus.dmem_rvalid_i = 1'b1;
        bus.dmem_rdata_i  = 32'h5555_AAAA;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk1("idle_rvalid_ignored", bus.mem_busy_o, 1'b0);
            @(posedge clk);
            #1;
        end
        bus.dmem_rvalid_i = 1'b0;

        issue(2'd1, 32'h0000_0300, 32'h0, 1'b1, 5'd8);
        @(negedge clk);
        bus.dmem_gnt_i = 1'b1;
        @(posedge clk);
        #1;
        bus.dmem_gnt_i = 1'b0;
        @(posedge clk);
        #2;
        arstn = 1'b0;
        #1;
        chk1 ("arst_in_ready", bus.in_ready_o, 1'b1);
        chk1 ("arst_busy", bus.mem_busy_o, 1'b0);
        chk1 ("arst_req", bus.dmem_req_o, 1'b0);
        chk1 ("arst_wb_valid", bus.wb_valid_o, 1'b0);
        check("arst_wb_data", bus.wb_data_o, 32'h0);
        chk1 ("arst_wb_wr", bus.wb_wr_o, 1'b0);
        check("arst_addr", bus.dmem_addr_o, 32'h0);
        chk1 ("arst_err", bus.mem_err_o, 1'b0);
        expq.delete();
        m_data = '0;
        m_dst  = '0;
        m_wr   = 1'b0;
        @(negedge clk);
        arstn = 1'b1;
        @(posedge clk);
        #1;
        bus.dmem_rvalid_i = 1'b1;
        bus.dmem_rdata_i  = 32'h7777_8888;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk1("late_rvalid_no_wb", bus.wb_valid_o, 1'b0);
            chk1("late_rvalid_no_err", bus.mem_err_o, 1'b0);
            @(posedge clk);
            #1;
        end
        bus.dmem_rvalid_i = 1'b0;

        run_none(2'd0, 32'h0000_0055, 1'b1, 5'd1);
        repeat (2) @(posedge clk);
        #1;
        check("queue_drained", 32'(expq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
